// File: rtl/seq_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared state encoding and default sizing for seq_pattern_gen.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int REP_W_DEF = 4;
    localparam int GAP_DEF   = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // A request is usable only with a non-empty pattern that fits and at least one repetition.
    function automatic logic req_ok(input int unsigned len, input int unsigned reps,
                                    input int unsigned width);
        return (len != 0) && (len <= width) && (reps != 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen_if
// Purpose  : Request/serial-output bundle between a requester and the generator.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_pattern_gen_if
    import seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int REP_W = REP_W_DEF
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, reps, abort,
        input  x, x_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, reps, abort,
        output x, x_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_gen_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_down_counter
// Purpose  : Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module seq_down_counter #(
    parameter int W = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_load_val,
    input  wire logic         i_dec,
    output logic      [W-1:0] o_count,
    output logic              o_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Purpose  : Shifts a latched pattern out MSB-first, repeated with idle gaps.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int REP_W = REP_W_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    seq_pattern_gen_if.slave bus
);
    // The index counter doubles as the gap timer, so the gap length must fit in LEN_W.
    localparam logic [LEN_W-1:0] c_gap_m1 = (GAP > 0) ? LEN_W'(GAP - 1) : '0;

    state_t           r_state;
    logic [WIDTH-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_x;
    logic             r_x_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_abort;
    logic             w_bit;
    logic             w_last_rep;

    logic             w_idx_load;
    logic [LEN_W-1:0] w_idx_val;
    logic             w_idx_dec;
    logic [LEN_W-1:0] w_idx_count;
    logic             w_idx_zero;

    logic             w_rep_load;
    logic [REP_W-1:0] w_rep_val;
    logic             w_rep_dec;
    logic [REP_W-1:0] w_rep_count;
    logic             w_rep_zero;

    assign w_accept   = (r_state == ST_IDLE) && !r_busy && bus.start &&
                        req_ok(32'(bus.len), 32'(bus.reps), WIDTH);
    assign w_abort    = bus.abort && (r_state != ST_IDLE);
    assign w_bit      = |(r_pattern & (WIDTH'(1) << w_idx_count));
    assign w_last_rep = (w_rep_count == REP_W'(1));

    seq_down_counter #(.W(LEN_W)) u_idx_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idx_load),
        .i_load_val (w_idx_val),
        .i_dec      (w_idx_dec),
        .o_count    (w_idx_count),
        .o_zero     (w_idx_zero)
    );

    seq_down_counter #(.W(REP_W)) u_rep_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_rep_load),
        .i_load_val (w_rep_val),
        .i_dec      (w_rep_dec),
        .o_count    (w_rep_count),
        .o_zero     (w_rep_zero)
    );

    always_comb begin
        w_idx_load = 1'b0;
        w_idx_val  = '0;
        w_idx_dec  = 1'b0;
        w_rep_load = 1'b0;
        w_rep_val  = '0;
        w_rep_dec  = 1'b0;
        if (!w_abort) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_idx_load = 1'b1;
                        w_idx_val  = bus.len - LEN_W'(1);
                        w_rep_load = 1'b1;
                        w_rep_val  = bus.reps;
                    end
                end
                ST_SEND: begin
                    if (w_idx_zero) begin
                        w_rep_dec = !w_rep_zero;
                        if (!w_last_rep) begin
                            w_idx_load = 1'b1;
                            w_idx_val  = (GAP > 0) ? c_gap_m1 : (r_len - LEN_W'(1));
                        end
                    end else begin
                        w_idx_dec = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_idx_zero) begin
                        w_idx_load = 1'b1;
                        w_idx_val  = r_len - LEN_W'(1);
                    end else begin
                        w_idx_dec = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_abort) begin
            r_state   <= ST_IDLE;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    if (w_accept) begin
                        r_pattern <= bus.pattern;
                        r_len     <= bus.len;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_x       <= w_bit;
                    r_x_valid <= 1'b1;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                    if (w_idx_zero) begin
                        if (w_last_rep) begin
                            r_state <= ST_DONE;
                        end else if (GAP > 0) begin
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                    if (w_idx_zero) begin
                        r_state <= ST_SEND;
                    end
                end
                default: begin
                    // Single DONE cycle; busy stays up so a new start lands after it.
                    r_x       <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.x       = r_x;
    assign bus.x_valid = r_x_valid;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Purpose  : Drives a GAP=2 and a GAP=0 generator in lockstep against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;
    import seq_pkg::*;

    typedef struct packed {
        logic x;
        logic xv;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0] pattern;
        logic [3:0] len;
        logic [3:0] reps;
        bit         accept;
        bit         abort_rep2;
        int         busy_start;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    exp_t exp2[$];
    exp_t exp0[$];
    exp_t e2, e0;
    vec_t vecs[12];

    seq_pattern_gen_if #(.WIDTH(8), .LEN_W(4), .REP_W(4)) if2 ();
    seq_pattern_gen_if #(.WIDTH(8), .LEN_W(4), .REP_W(4)) if0 ();

    seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(2)) u_gap2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP(0)) u_gap0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got {x,xv,busy,done}=%b want %b", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] out2();
        return {if2.x, if2.x_valid, if2.busy, if2.done};
    endfunction

    function automatic logic [3:0] out0();
        return {if0.x, if0.x_valid, if0.busy, if0.done};
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        if (exp2.size() != 0) begin
            e2 = exp2.pop_front();
            check("gap2_stream", out2(), e2);
        end
        if (exp0.size() != 0) begin
            e0 = exp0.pop_front();
            check("gap0_stream", out0(), e0);
        end
    end

    task automatic set_req(input bit s, input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] r);
        if2.start = s; if2.pattern = p; if2.len = l; if2.reps = r;
        if0.start = s; if0.pattern = p; if0.len = l; if0.reps = r;
    endtask

    // Expected samples start with the one taken just after the accepting edge.
    task automatic push_model(input int g, input logic [7:0] p, input int len, input int reps,
                              input bit acc, input int ab);
        exp_t       q[$];
        logic [7:0] t;
        if (!acc) begin
            repeat (3) q.push_back(4'b0000);
        end else begin
            q.push_back(4'b0000);
            for (int r = 0; r < reps; r++) begin
                for (int i = len - 1; i >= 0; i--) begin
                    t = p >> i;
                    q.push_back({t[0], 1'b1, 1'b1, 1'b0});
                end
                if (r < reps - 1) repeat (g) q.push_back(4'b0010);
            end
            q.push_back(4'b0011);
            q.push_back(4'b0000);
        end
        for (int i = 0; i < q.size(); i++) begin
            if (i == ab) begin
                if (g == 2) exp2.push_back(4'b0000); else exp0.push_back(4'b0000);
                break;
            end
            if (g == 2) exp2.push_back(q[i]); else exp0.push_back(q[i]);
        end
    endtask

    // Called at a negedge; returns at the negedge where both queues have drained.
    task automatic run_vec(input vec_t v);
        int ab2;
        int ab0;
        bit drained;
        ab2     = v.abort_rep2 ? 3 + int'(v.len) + 2 : -1;
        ab0     = v.abort_rep2 ? 3 + int'(v.len)     : -1;
        drained = 1'b0;
        set_req(1'b1, v.pattern, v.len, v.reps);
        push_model(2, v.pattern, int'(v.len), int'(v.reps), v.accept, ab2);
        push_model(0, v.pattern, int'(v.len), int'(v.reps), v.accept, ab0);
        for (int n = 1; n < 400; n++) begin
            @(negedge clk);
            if2.abort = (n == ab2);
            if0.abort = (n == ab0);
            if (n == v.busy_start) set_req(1'b1, 8'hFF, 4'd8, 4'd7);
            else                   set_req(1'b0, ~v.pattern, v.len, v.reps);
            if (exp2.size() == 0 && exp0.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain_in_budget", {3'b000, drained}, 4'b0001);
    endtask

    initial begin
        vecs[0]  = '{8'b0000_1011, 4'd4, 4'd1,  1'b1, 1'b0, 0};
        vecs[1]  = '{8'b0000_1011, 4'd4, 4'd3,  1'b1, 1'b0, 0};
        vecs[2]  = '{8'b0000_1101, 4'd4, 4'd2,  1'b1, 1'b0, 0};
        vecs[3]  = '{8'b0000_1011, 4'd0, 4'd1,  1'b0, 1'b0, 0};
        vecs[4]  = '{8'b0000_1011, 4'd4, 4'd0,  1'b0, 1'b0, 0};
        vecs[5]  = '{8'b1111_1111, 4'd9, 4'd1,  1'b0, 1'b0, 0};
        vecs[6]  = '{8'hA5,        4'd8, 4'd2,  1'b1, 1'b0, 0};
        vecs[7]  = '{8'h01,        4'd1, 4'd3,  1'b1, 1'b0, 0};
        vecs[8]  = '{8'b0000_1011, 4'd4, 4'd3,  1'b1, 1'b1, 0};
        vecs[9]  = '{8'b0000_0110, 4'd3, 4'd1,  1'b1, 1'b0, 0};
        vecs[10] = '{8'hC3,        4'd8, 4'd2,  1'b1, 1'b0, 3};
        vecs[11] = '{8'b0000_0010, 4'd2, 4'd15, 1'b1, 1'b0, 0};

        set_req(1'b0, 8'h00, 4'd0, 4'd0);
        if2.abort = 1'b0;
        if0.abort = 1'b0;
        @(posedge clk);
        #1;
        check("reset_gap2", out2(), 4'b0000);
        check("reset_gap0", out0(), 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Asynchronous reset landing between edges mid-transmission.
        set_req(1'b1, 8'b0000_1011, 4'd4, 4'd2);
        @(negedge clk);
        set_req(1'b0, 8'b0000_1011, 4'd4, 4'd2);
        repeat (2) @(posedge clk);
        #3;
        check("pre_rst_gap2", out2(), 4'b0110);
        check("pre_rst_gap0", out0(), 4'b0110);
        rst = 1'b1;
        #1;
        check("async_rst_gap2", out2(), 4'b0000);
        check("async_rst_gap0", out0(), 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_gap2", out2(), 4'b0000);
        check("post_rst_gap0", out0(), 4'b0000);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
